punc_state_dumper: RTL and testbench
====================================

Name: punc_state_dumper

Overview:
- Debug-side consumer that sits directly downstream of the processor top's debug outputs.
- On a start pulse it snapshots the PC, then R0..R7, then a range of data memory. It drives the debug address ports and streams each word out over a valid/ready interface.
- Lets the test harness or UART bridge dump architectural state without hierarchical peeking.

Parameters:
- MEM_RD_LAT, 1, cycles from driving mem_debug_addr until mem_debug_data is valid (0..7; 0 = combinational).
- RF_WORDS, 8, number of registers dumped, starting at R0 (1..8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- start  in  1  one-cycle request to begin a dump.
- mem_base  in  16  first memory address to dump; sampled on accepted start.
- mem_count  in  16  number of memory words to dump; sampled on accepted start.
- busy  out  1  high from accepted start until the last word is accepted.
- done  out  1  one-cycle pulse, asserted the cycle after the last handshake.
- mem_debug_addr  out  16  address to the processor's memory debug port.
- rf_debug_addr  out  3  address to the processor's register-file debug port.
- mem_debug_data  in  16  memory debug read data.
- rf_debug_data  in  16  register-file debug read data (combinational).
- pc_debug_data  in  16  current PC.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream ready.
- out_data  out  16  stream word.
- out_kind  out  2  word type: 0 = PC, 1 = RF, 2 = MEM, 3 = CHECKSUM.
- out_index  out  16  register number, or absolute memory address; 0 for PC and checksum words.
- out_last  out  1  marks the final word of the dump.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-dump aborts immediately; the partial dump is not resumed.
- States: IDLE, PC, RF_ISSUE, MEM_ISSUE, MEM_WAIT, EMIT, DONE.
- IDLE:
  - start=1 samples mem_base and mem_count, sets busy, and moves to PC.
  - start while busy is ignored.
- PC: captures pc_debug_data into the output register and moves to EMIT with kind 0.
- RF_ISSUE:
  - Drives rf_debug_addr = register index.
  - Captures rf_debug_data in the same cycle and moves to EMIT with kind 1, index = register number.
- MEM_ISSUE: drives mem_debug_addr = current address.
  - MEM_RD_LAT=0: captures in the same cycle and moves to EMIT.
  - Otherwise: moves to MEM_WAIT, which counts MEM_RD_LAT-1 further cycles. It captures on the cycle the count expires (exactly MEM_RD_LAT cycles after issue), then moves to EMIT with kind 2, index = address.
- mem_debug_addr holds its value from issue through capture.
- EMIT:
  - out_valid=1.
  - out_data, out_kind, out_index and out_last are held stable while out_valid && !out_ready.
  - On the handshake, the next state is chosen in this order: next RF, then MEM, then CHECKSUM (if enabled), else DONE.
- One word per handshake. Minimum spacing between words is 2 cycles (issue/capture, emit). No prefetch.
- Sequence order: PC, R0..R(RF_WORDS-1), mem[base .. base+count-1].
- Address arithmetic is 16-bit and wraps: base 0xFFFF, count 2 emits 0xFFFF then 0x0000.
- mem_count=0 skips memory entirely; out_last is then set on the final RF word (or on the checksum when enabled).
- DONE: pulses done for one cycle, clears busy, returns to IDLE. A start in the DONE cycle is ignored.
- The outputs are a snapshot per word only. The dumper does not stall the processor; the harness is responsible for halting it before start.

Optional Feature:
- Macro: PUNC_DUMP_CHECKSUM_EN.
- Defined:
  - A 16-bit running sum (mod 2^16) of every emitted out_data is kept and cleared on accepted start.
  - After the final data word, one extra word is emitted with kind 3, index 0, data = sum, carrying out_last.
- Undefined: no accumulator and no checksum word; out_last goes on the final PC/RF/MEM word. kind 3 is never produced.

Decomposition:
- Shared package: dump-kind constants (KIND_PC, KIND_RF, KIND_MEM, KIND_CSUM), the FSM state encoding, and the 16-bit word width constant.
- One natural sub-module: punc_dump_out_reg, the output holding register with valid/ready skid-free hold logic.
- Sequencing FSM, latency counter and address counters stay in punc_state_dumper.

Test Plan:
- Basic dump:
  - Stimulus: pc=0x3000, Rn=0x1110*n, mem[0x40..0x42]=0xA,0xB,0xC; start with base=0x0040, count=3; out_ready tied high.
  - Expect 12 words: PC 0x3000; RF 0x0000..0x7770 with indices 0..7; MEM 0xA/0xB/0xC with indices 0x40..0x42.
  - out_last on 0xC only; done one cycle later.
- Backpressure:
  - Stimulus: toggle out_ready 1010… with random stalls.
  - Expect identical word sequence; out_data/out_kind/out_index stable throughout each stalled cycle.
- count=0: out_last on R7 (0x7770), 9 words total, mem_debug_addr never leaves 0.
- Wrap and latency:
  - Stimulus: MEM_RD_LAT=3, base=0xFFFF, count=2.
  - Expect indices 0xFFFF then 0x0000; capture exactly 3 cycles after issue.
- Reset mid-dump and start while busy:
  - Stimulus: assert rst low during the R3 EMIT; separately, pulse start mid-dump.
  - Expect: on reset, out_valid/busy/done go to 0 asynchronously and state is IDLE. A start pulse mid-dump leaves the sequence unaffected.
- PUNC_DUMP_CHECKSUM_EN:
  - Stimulus: scenario 1 with the macro defined.
  - Expect a 13th word, kind 3, data = 16-bit sum of all 12 prior words, carrying out_last. Word 12 (0xC) no longer has out_last.

Source files
------------

// File: rtl/punc_state_dumper_pkg.sv
// Shared definitions for the architectural state dumper.
//   WORD_W        : width of every streamed word, address and index
//   KIND_*        : out_kind encodings (PC, RF, MEM, CHECKSUM)
//   state_t       : sequencing FSM states
//   dump_word_t   : one streamed record (data, kind, index, last)
// Build option: PUNC_DUMP_CHECKSUM_EN (used by punc_state_dumper).
package punc_state_dumper_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [1:0] KIND_PC   = 2'd0;
  localparam logic [1:0] KIND_RF   = 2'd1;
  localparam logic [1:0] KIND_MEM  = 2'd2;
  localparam logic [1:0] KIND_CSUM = 2'd3;

  // ST_CSUM is only reachable when the checksum word is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC,
    ST_RF_ISSUE,
    ST_MEM_ISSUE,
    ST_MEM_WAIT,
    ST_EMIT,
    ST_CSUM,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [1:0]        kind;
    logic [WORD_W-1:0] index;
    logic              last;
  } dump_word_t;

endpackage

// File: rtl/punc_state_dumper_out_reg.sv
// Output holding register for the dump stream.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   load, load_*      : new word from the sequencer (accepted only when the
//                       register is empty or being drained this cycle)
//   out_ready         : downstream ready
//   out_valid, out_*  : registered stream word, held stable while stalled
//   fire              : handshake this cycle (out_valid && out_ready)
module punc_dump_out_reg
  import punc_state_dumper_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [1:0]        load_kind,
  input  logic [WORD_W-1:0] load_index,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [1:0]        out_kind,
  output logic [WORD_W-1:0] out_index,
  output logic              out_last,
  output logic              fire
);

  logic can_load;

  assign fire     = out_valid & out_ready;
  // A pending word must never be overwritten before it is accepted.
  assign can_load = load & (~out_valid | out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_kind  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (can_load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_kind  <= load_kind;
      out_index <= load_index;
      out_last  <= load_last;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/punc_state_dumper.sv
// Architectural state dumper: on start, streams PC, R0..R(RF_WORDS-1) and
// mem[mem_base .. mem_base+mem_count-1] over a valid/ready interface.
// Parameters:
//   MEM_RD_LAT : cycles from mem_debug_addr to valid mem_debug_data (0..7)
//   RF_WORDS   : registers dumped starting at R0 (1..8)
// Ports:
//   clk, rst (async, active-low), start, mem_base, mem_count
//   busy, done                        : status
//   mem_debug_addr/data, rf_debug_addr/data, pc_debug_data : processor debug side
//   out_valid/ready/data/kind/index/last : dump stream
// Build option: define PUNC_DUMP_CHECKSUM_EN to append a 16-bit running-sum
// word (kind 3) that then carries out_last.
module punc_state_dumper
  import punc_state_dumper_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned RF_WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mem_base,
  input  logic [15:0] mem_count,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_debug_addr,
  output logic [2:0]  rf_debug_addr,
  input  logic [15:0] mem_debug_data,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] pc_debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_kind,
  output logic [15:0] out_index,
  output logic        out_last
);

`ifdef PUNC_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [2:0] RF_LAST   = 3'(RF_WORDS - 1);
  localparam logic [2:0] WAIT_INIT = (MEM_RD_LAT == 0) ? 3'd0 : 3'(MEM_RD_LAT - 1);

  state_t      state, state_nxt;
  logic [2:0]  rf_idx;
  logic [15:0] mem_cur;
  logic [15:0] mem_left;
  logic [15:0] mem_addr_q;
  logic [2:0]  lat_cnt;
  logic [15:0] csum_word;

  logic        ld;
  logic [15:0] ld_data;
  logic [1:0]  ld_kind;
  logic [15:0] ld_index;
  logic        ld_last;
  logic        fire;

  logic        accept_start;
  logic        rf_more;
  state_t      tail_state;

  assign accept_start = (state == ST_IDLE) && start;
  assign rf_more      = (rf_idx != RF_LAST);
  assign tail_state   = CSUM_EN ? ST_CSUM : ST_DONE;

  // The address is live in the issue cycle and then held from a register so
  // it stays put through the wait and emit cycles (and stays 0 if memory is
  // never touched).
  assign mem_debug_addr = (state == ST_MEM_ISSUE) ? mem_cur : mem_addr_q;
  assign rf_debug_addr  = rf_idx;
  assign busy           = (state != ST_IDLE) && (state != ST_DONE);
  assign done           = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ld_data   = '0;
    ld_kind   = KIND_PC;
    ld_index  = '0;
    ld_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_PC;
      end
      ST_PC: begin
        ld        = 1'b1;
        ld_data   = pc_debug_data;
        ld_kind   = KIND_PC;
        state_nxt = ST_EMIT;
      end
      ST_RF_ISSUE: begin
        ld        = 1'b1;
        ld_data   = rf_debug_data;
        ld_kind   = KIND_RF;
        ld_index  = {13'd0, rf_idx};
        ld_last   = !rf_more && (mem_left == 16'd0) && !CSUM_EN;
        state_nxt = ST_EMIT;
      end
      ST_MEM_ISSUE: begin
        if (MEM_RD_LAT == 0) begin
          ld        = 1'b1;
          ld_data   = mem_debug_data;
          ld_kind   = KIND_MEM;
          ld_index  = mem_cur;
          ld_last   = (mem_left == 16'd1) && !CSUM_EN;
          state_nxt = ST_EMIT;
        end else begin
          state_nxt = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (lat_cnt == 3'd0) begin
          ld        = 1'b1;
          ld_data   = mem_debug_data;
          ld_kind   = KIND_MEM;
          ld_index  = mem_cur;
          ld_last   = (mem_left == 16'd1) && !CSUM_EN;
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (fire) begin
          case (out_kind)
            KIND_PC: state_nxt = ST_RF_ISSUE;
            KIND_RF: begin
              if (rf_more)                  state_nxt = ST_RF_ISSUE;
              else if (mem_left != 16'd0)   state_nxt = ST_MEM_ISSUE;
              else                          state_nxt = tail_state;
            end
            KIND_MEM: begin
              if (mem_left != 16'd1) state_nxt = ST_MEM_ISSUE;
              else                   state_nxt = tail_state;
            end
            default: state_nxt = ST_DONE;
          endcase
        end
      end
      ST_CSUM: begin
        ld        = 1'b1;
        ld_data   = csum_word;
        ld_kind   = KIND_CSUM;
        ld_last   = 1'b1;
        state_nxt = ST_EMIT;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_idx     <= '0;
      mem_cur    <= '0;
      mem_left   <= '0;
      mem_addr_q <= '0;
      lat_cnt    <= '0;
    end else begin
      if (accept_start) begin
        rf_idx   <= '0;
        mem_cur  <= mem_base;
        mem_left <= mem_count;
      end
      if (state == ST_MEM_ISSUE) begin
        mem_addr_q <= mem_cur;
        lat_cnt    <= WAIT_INIT;
      end
      if ((state == ST_MEM_WAIT) && (lat_cnt != 3'd0)) lat_cnt <= lat_cnt - 3'd1;
      if (fire && (out_kind == KIND_RF) && rf_more) rf_idx <= rf_idx + 3'd1;
      // Address wraps naturally in 16 bits.
      if (fire && (out_kind == KIND_MEM)) begin
        mem_cur  <= mem_cur + 16'd1;
        mem_left <= mem_left - 16'd1;
      end
    end
  end

`ifdef PUNC_DUMP_CHECKSUM_EN
  logic [15:0] csum;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              csum <= '0;
    else if (accept_start) csum <= '0;
    else if (fire)         csum <= csum + out_data;
  end
  assign csum_word = csum;
`else
  assign csum_word = '0;
`endif

  punc_dump_out_reg u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .load_data  (ld_data),
    .load_kind  (ld_kind),
    .load_index (ld_index),
    .load_last  (ld_last),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_kind   (out_kind),
    .out_index  (out_index),
    .out_last   (out_last),
    .fire       (fire)
  );

endmodule

// File: tb/tb_punc_state_dumper.sv
// Self-checking bench for punc_state_dumper (MEM_RD_LAT=3, RF_WORDS=8).
// Honours PUNC_DUMP_CHECKSUM_EN when defined for the build.
module tb_punc_state_dumper;

  localparam int unsigned LAT = 3;
`ifdef PUNC_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk, rst, start;
  logic [15:0] mem_base, mem_count;
  logic        busy, done;
  logic [15:0] mem_debug_addr;
  logic [2:0]  rf_debug_addr;
  logic [15:0] mem_debug_data, rf_debug_data, pc_debug_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_kind;
  logic [15:0] out_index;
  logic        out_last;

  punc_state_dumper #(.MEM_RD_LAT(LAT), .RF_WORDS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_base(mem_base), .mem_count(mem_count),
    .busy(busy), .done(done), .mem_debug_addr(mem_debug_addr), .rf_debug_addr(rf_debug_addr),
    .mem_debug_data(mem_debug_data), .rf_debug_data(rf_debug_data), .pc_debug_data(pc_debug_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_kind(out_kind),
    .out_index(out_index), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor model: PC, register file, and a memory with LAT-cycle read pipe.
  logic [15:0] mem_m [65536];
  logic [15:0] rf_m  [8];
  logic [15:0] pc_val;
  logic [15:0] apipe [LAT];

  assign rf_debug_data  = rf_m[rf_debug_addr];
  assign pc_debug_data  = pc_val;
  assign mem_debug_data = mem_m[apipe[LAT-1]];

  always @(posedge clk) begin
    apipe[0] <= mem_debug_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  kind;
    logic [15:0] index;
    logic        last;
  } word_t;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    rmode = 0;
  bit    tog = 1'b0;
  bit    collecting = 1'b0;
  bit    prev_stall = 1'b0;
  bit    addr_moved = 1'b0;
  word_t prev_word;
  word_t got_q[$];
  int    got_cyc[$];
  int    done_cyc[$];
  word_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: 0 = tied high, 1 = 1010.. with random extra stalls, 2 = held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          tog = !tog;
          out_ready = tog && ($urandom_range(0, 3) != 0);
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    word_t cur;
    cur = {out_data, out_kind, out_index, out_last};
    if (collecting) begin
      if (prev_stall)
        check("stall_hold", 64'({out_valid, cur}), 64'({1'b1, prev_word}));
      if (out_valid && out_ready) begin
        got_q.push_back(cur);
        got_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (mem_debug_addr != 16'd0) addr_moved = 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_word  = cur;
    end
  end

  // Reference: the dump is PC, then every register, then the memory window,
  // optionally followed by the 16-bit sum of all of those.
  task automatic build_expected(input logic [15:0] base, input int count);
    logic [15:0] sum;
    logic [15:0] a;
    exp_q.delete();
    exp_q.push_back('{data: pc_val, kind: 2'd0, index: 16'd0, last: 1'b0});
    for (int r = 0; r < 8; r++)
      exp_q.push_back('{data: rf_m[r], kind: 2'd1, index: 16'(r), last: 1'b0});
    for (int i = 0; i < count; i++) begin
      a = base + 16'(i);
      exp_q.push_back('{data: mem_m[a], kind: 2'd2, index: a, last: 1'b0});
    end
    if (CS) begin
      sum = 16'd0;
      foreach (exp_q[i]) sum = sum + exp_q[i].data;
      exp_q.push_back('{data: sum, kind: 2'd3, index: 16'd0, last: 1'b0});
    end
    exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  task automatic run_dump(input string tag, input logic [15:0] base, input int count,
                          input int rm, input bit mid, input int exp_n,
                          input bit chk_last, input logic [15:0] exp_last);
    int s_cyc;
    int gap;
    build_expected(base, count);
    got_q.delete(); got_cyc.delete(); done_cyc.delete();
    addr_moved = 1'b0;
    prev_stall = 1'b0;
    rmode = rm;
    @(posedge clk); #1;
    collecting = 1'b1;
    start = 1'b1; mem_base = base; mem_count = 16'(count);
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; mem_base = 16'($urandom); mem_count = 16'($urandom);
    check({tag, "_busy_set"}, 64'(busy), 64'd1);
    for (int k = 0; k < 3000 && done_cyc.size() == 0; k++) begin
      @(posedge clk); #1;
      if (mid && k == 6) begin
        start = 1'b1; mem_base = 16'h1234; mem_count = 16'd5;
      end else start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    collecting = 1'b0;
    check({tag, "_done_pulses"}, 64'(done_cyc.size()), 64'd1);
    check({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_n));
    check({tag, "_nwords_model"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    if (chk_last && got_q.size() > 0)
      check({tag, "_last_data"}, 64'(got_q[got_q.size()-1].data), 64'(exp_last));
    if (got_q.size() > 0 && done_cyc.size() > 0)
      check({tag, "_done_timing"}, 64'(done_cyc[0]), 64'(got_cyc[got_cyc.size()-1] + 1));
    check({tag, "_idle_after"}, 64'({busy, out_valid, done}), 64'd0);
    if (rm == 0 && got_q.size() == exp_q.size()) begin
      check({tag, "_first_gap"}, 64'(got_cyc[0]), 64'(s_cyc + 2));
      for (int i = 1; i < got_q.size(); i++) begin
        gap = (exp_q[i].kind == 2'd2) ? int'(LAT) + 2 : 2;
        check($sformatf("%s_gap%0d", tag, i), 64'(got_cyc[i] - got_cyc[i-1]), 64'(gap));
      end
    end
  endtask

  task automatic reset_mid();
    bit hit;
    rmode = 0;
    @(posedge clk); #1;
    start = 1'b1; mem_base = 16'h0040; mem_count = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      hit = out_valid && out_kind == 2'd1 && out_index == 16'd2;
    end
    rmode = 2;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      hit = out_valid && out_kind == 2'd1 && out_index == 16'd3 && !out_ready;
    end
    check("rst_reach_r3", 64'(hit), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_async_outputs",
          64'({out_valid, busy, done, out_last, out_kind}), 64'd0);
    check("rst_async_data", 64'({out_data, out_index, mem_debug_addr}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rmode = 0;
    repeat (6) @(negedge clk);
    check("rst_no_resume", 64'({busy, out_valid, done}), 64'd0);
  endtask

  typedef struct {
    logic [15:0] base;
    int          count;
    int          rm;
    bit          mid;
    int          exp_n;
    logic [15:0] exp_last;
  } vec_t;

  vec_t tbl[5];

  initial begin
    rst = 1'b0; start = 1'b0; mem_base = '0; mem_count = '0;
    pc_val = 16'h3000;
    for (int i = 0; i < 8; i++) rf_m[i] = 16'(16'h1110 * i);
    for (int i = 0; i < 65536; i++) mem_m[i] = 16'(i) ^ 16'hA5C3;
    mem_m[16'h0040] = 16'h000A;
    mem_m[16'h0041] = 16'h000B;
    mem_m[16'h0042] = 16'h000C;
    mem_m[16'hFFFF] = 16'h1234;
    mem_m[16'h0000] = 16'h0F0F;
    for (int i = 0; i < LAT; i++) apipe[i] = '0;

    //            base     cnt rm mid  words         final data word
    tbl[0] = '{16'h0040, 0, 0, 0, 9  + int'(CS), CS ? 16'h0DC0 : 16'h7770};
    tbl[1] = '{16'h0040, 3, 0, 0, 12 + int'(CS), CS ? 16'h0DE1 : 16'h000C};
    tbl[2] = '{16'h0040, 3, 1, 1, 12 + int'(CS), CS ? 16'h0DE1 : 16'h000C};
    tbl[3] = '{16'hFFFF, 2, 0, 0, 11 + int'(CS), CS ? 16'h2F03 : 16'h0F0F};
    tbl[4] = '{16'hFFFF, 2, 1, 1, 11 + int'(CS), CS ? 16'h2F03 : 16'h0F0F};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          64'({out_valid, busy, done, out_last, out_kind, out_data, out_index}), 64'd0);
    rst = 1'b1;

    for (int t = 0; t < 5; t++) begin
      run_dump($sformatf("v%0d", t), tbl[t].base, tbl[t].count, tbl[t].rm,
               tbl[t].mid, tbl[t].exp_n, 1'b1, tbl[t].exp_last);
      if (t == 0) check("cnt0_mem_addr_idle", 64'(addr_moved), 64'd0);
    end

    reset_mid();
    run_dump("after_rst", tbl[1].base, tbl[1].count, 0, 0, tbl[1].exp_n, 1'b1, tbl[1].exp_last);

    for (int r = 0; r < 6; r++) begin
      int cnt;
      pc_val = 16'($urandom);
      for (int i = 0; i < 8; i++) rf_m[i] = 16'($urandom);
      cnt = $urandom_range(0, 5);
      run_dump($sformatf("rnd%0d", r), 16'($urandom), cnt, $urandom_range(0, 1),
               1'($urandom_range(0, 1)), 9 + cnt + int'(CS), 1'b0, 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
